// File: rtl/timer_tick_scheduler_pkg.sv
// Shared definitions for the interval-timer scheduler: timer register map,
// control/status bit positions, FSM state encodings and the bus command record.
package timer_tick_scheduler_pkg;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int STAT_RUN = 1;

  localparam logic [15:0] CTRL_RUN_WORD  = 16'((1 << CTRL_ITO) | (1 << CTRL_CONT) | (1 << CTRL_START));
  localparam logic [15:0] CTRL_STOP_WORD = 16'(1 << CTRL_STOP);

  // The timer cannot run continuously with a load value below 2.
  localparam logic [31:0] MIN_PERIOD = 32'd2;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_WR_PL    = 4'd1;
  localparam logic [3:0] ST_WR_PH    = 4'd2;
  localparam logic [3:0] ST_WR_CTRL  = 4'd3;
  localparam logic [3:0] ST_VERIFY   = 4'd4;
  localparam logic [3:0] ST_CHECK    = 4'd5;
  localparam logic [3:0] ST_RUN      = 4'd6;
  localparam logic [3:0] ST_ACK      = 4'd7;
  localparam logic [3:0] ST_ACK_WAIT = 4'd8;
  localparam logic [3:0] ST_STOP     = 4'd9;

  typedef struct packed {
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
  } bus_cmd_t;

endpackage

// File: rtl/timer_tick_scheduler_tick_divider.sv
// One divided tick channel: counts base ticks and pulses every div+1 of them.
module timer_tick_scheduler_tick_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             base_tick,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;
  logic             hit;

  // Exact-match compare: a divider lowered below the count lets it run to wrap first.
  assign hit  = (cnt_reg == div);
  assign tick = base_tick & en & hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (!en || clr) begin
      cnt_reg <= '0;
    end else if (base_tick) begin
      cnt_reg <= hit ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/timer_tick_scheduler.sv
// Avalon-MM master that programs, starts, acknowledges and stops the interval
// timer, and fans each acknowledged timeout out to N_CH divided tick channels.
module timer_tick_scheduler
  import timer_tick_scheduler_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DIV_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           cfg_period,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH*DIV_W-1:0] ch_div,
  output logic [2:0]            tmr_address,
  output logic                  tmr_chipselect,
  output logic                  tmr_write_n,
  output logic [15:0]           tmr_writedata,
  input  logic [15:0]           tmr_readdata,
  input  logic                  tmr_irq,
  output logic                  running,
  output logic                  busy,
  output logic                  cfg_error,
  output logic                  base_tick,
  output logic [N_CH-1:0]       tick,
  output logic [31:0]           tick_count
);

  logic [3:0]  state_reg, state_next;
  logic [31:0] period_reg;
  logic [31:0] tick_count_reg;
  logic        running_reg, cfg_error_reg, stop_pend_reg;
  logic        start_window, start_accept, start_reject;
  logic        stop_req, verify_ok, unused_readdata;
  bus_cmd_t    bus_cmd;

  assign start_window    = (state_reg == ST_IDLE) || (state_reg == ST_RUN);
  assign start_accept    = start_window & cfg_start & (cfg_period >= MIN_PERIOD);
  assign start_reject    = start_window & cfg_start & (cfg_period < MIN_PERIOD);
  assign stop_req        = cfg_stop | stop_pend_reg;
  assign verify_ok       = tmr_readdata[STAT_RUN];
  assign unused_readdata = ^tmr_readdata;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (start_accept) state_next = ST_WR_PL;
      ST_WR_PL:    state_next = ST_WR_PH;
      ST_WR_PH:    state_next = ST_WR_CTRL;
      ST_WR_CTRL:  state_next = ST_VERIFY;
      ST_VERIFY:   state_next = ST_CHECK;
      ST_CHECK:    state_next = verify_ok ? (stop_req ? ST_STOP : ST_RUN) : ST_IDLE;
      // cfg_start outranks stop and irq; a rejected start just holds RUN this cycle.
      ST_RUN: begin
        if (cfg_start)     state_next = start_accept ? ST_WR_PL : ST_RUN;
        else if (stop_req) state_next = ST_STOP;
        else if (tmr_irq)  state_next = ST_ACK;
      end
      ST_ACK:      state_next = ST_ACK_WAIT;
      ST_ACK_WAIT: state_next = ST_RUN;
      ST_STOP:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_cmd = '{address: REG_STATUS, chipselect: 1'b0, write_n: 1'b1, writedata: 16'h0000};
    case (state_reg)
      ST_WR_PL:   bus_cmd = '{address: REG_PERIODL, chipselect: 1'b1, write_n: 1'b0, writedata: period_reg[15:0]};
      ST_WR_PH:   bus_cmd = '{address: REG_PERIODH, chipselect: 1'b1, write_n: 1'b0, writedata: period_reg[31:16]};
      ST_WR_CTRL: bus_cmd = '{address: REG_CONTROL, chipselect: 1'b1, write_n: 1'b0, writedata: CTRL_RUN_WORD};
      ST_VERIFY:  bus_cmd = '{address: REG_STATUS, chipselect: 1'b1, write_n: 1'b1, writedata: 16'h0000};
      ST_ACK:     bus_cmd = '{address: REG_STATUS, chipselect: 1'b1, write_n: 1'b0, writedata: 16'h0000};
      ST_STOP:    bus_cmd = '{address: REG_CONTROL, chipselect: 1'b1, write_n: 1'b0, writedata: CTRL_STOP_WORD};
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      period_reg     <= '0;
      tick_count_reg <= '0;
      running_reg    <= 1'b0;
      cfg_error_reg  <= 1'b0;
      stop_pend_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_accept) period_reg <= cfg_period;
      if (state_reg == ST_ACK) tick_count_reg <= tick_count_reg + 32'd1;

      if (start_accept)                               cfg_error_reg <= 1'b0;
      else if (start_reject)                          cfg_error_reg <= 1'b1;
      else if (state_reg == ST_CHECK && !verify_ok)   cfg_error_reg <= 1'b1;

      if (start_accept)                running_reg <= 1'b0;
      else if (state_reg == ST_CHECK)  running_reg <= verify_ok & ~stop_req;
      else if (state_reg == ST_STOP)   running_reg <= 1'b0;

      // A stop arriving mid-sequence is remembered until the STOP write goes out.
      if (start_accept || state_reg == ST_STOP || (state_reg == ST_CHECK && !verify_ok))
        stop_pend_reg <= 1'b0;
      else if (cfg_stop && !start_window)
        stop_pend_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    timer_tick_scheduler_tick_divider #(.DIV_W(DIV_W)) u_div (
      .clk       (clk),
      .reset_n   (reset_n),
      .base_tick (base_tick),
      .en        (ch_en[gi]),
      .clr       (start_accept),
      .div       (ch_div[gi*DIV_W +: DIV_W]),
      .tick      (tick[gi])
    );
  end

  assign tmr_address    = bus_cmd.address;
  assign tmr_chipselect = bus_cmd.chipselect;
  assign tmr_write_n    = bus_cmd.write_n;
  assign tmr_writedata  = bus_cmd.writedata;
  assign running        = running_reg;
  assign busy           = ~start_window;
  assign cfg_error      = cfg_error_reg;
  assign base_tick      = (state_reg == ST_ACK);
  assign tick_count     = tick_count_reg;

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Self-checking bench: a behavioural interval-timer slave plus scenario tasks
// comparing the scheduler against expectations derived from the timer rules.
module tb_timer_tick_scheduler;

  localparam int N_CH  = 4;
  localparam int DIV_W = 8;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [31:0]           cfg_period = '0;
  logic                  cfg_start = 1'b0;
  logic                  cfg_stop = 1'b0;
  logic [N_CH-1:0]       ch_en = '0;
  logic [N_CH*DIV_W-1:0] ch_div = '0;
  logic [2:0]            tmr_address;
  logic                  tmr_chipselect;
  logic                  tmr_write_n;
  logic [15:0]           tmr_writedata;
  logic [15:0]           tmr_readdata = '0;
  logic                  tmr_irq = 1'b0;
  logic                  running, busy, cfg_error, base_tick;
  logic [N_CH-1:0]       tick;
  logic [31:0]           tick_count;

  always #5 clk = ~clk;

  timer_tick_scheduler #(.N_CH(N_CH), .DIV_W(DIV_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_period     (cfg_period),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .ch_en          (ch_en),
    .ch_div         (ch_div),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_readdata   (tmr_readdata),
    .tmr_irq        (tmr_irq),
    .running        (running),
    .busy           (busy),
    .cfg_error      (cfg_error),
    .base_tick      (base_tick),
    .tick           (tick),
    .tick_count     (tick_count)
  );

  typedef struct {
    logic [2:0]  addr;
    logic        wr;
    logic [15:0] data;
  } xact_t;

  xact_t       bus_log[$];
  int          cyc = 0;
  int          irq_req = 0;
  int          irq_served = 0;
  int          irq_rise_cyc = 0;
  int          bt_cyc = 0;
  int          bt_cnt = 0;
  int          ack_cnt = 0;
  int          spur_ack = 0;
  int          orphan = 0;
  int          tick_cnt [N_CH] = '{default: 0};
  logic        run_bit = 1'b0;
  logic        stall = 1'b0;
  logic        rd_pend = 1'b0;
  logic        drop_pend = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_tc = '0;

  // Timer slave model and bus/tick monitor, all on the falling edge.
  always @(negedge clk) begin
    xact_t x;
    cyc++;
    tmr_readdata = rd_pend ? {14'd0, run_bit, tmr_irq} : 16'h0000;
    rd_pend = 1'b0;
    if (drop_pend) begin
      tmr_irq = 1'b0;
      drop_pend = 1'b0;
    end else if (!tmr_irq && run_bit && irq_req != irq_served) begin
      tmr_irq = 1'b1;
      irq_rise_cyc = cyc;
    end
    if (tmr_chipselect === 1'b1) begin
      x.addr = tmr_address;
      x.wr   = ~tmr_write_n;
      x.data = tmr_writedata;
      bus_log.push_back(x);
      $display("bus: cyc=%0d addr=%0d we=%0b data=%04h", cyc, x.addr, x.wr, x.data);
      if (tmr_write_n) begin
        rd_pend = (tmr_address == 3'd0);
      end else begin
        case (tmr_address)
          3'd0: begin
            ack_cnt++;
            if (tmr_irq) begin
              irq_served++;
              drop_pend = 1'b1;
            end else begin
              spur_ack++;
            end
          end
          3'd1: begin
            if (tmr_writedata[3]) run_bit = 1'b0;
            else if (tmr_writedata[2] && !stall) run_bit = 1'b1;
          end
          3'd2, 3'd3: run_bit = 1'b0;
          default: ;
        endcase
      end
    end
    if (base_tick === 1'b1) begin
      bt_cnt++;
      bt_cyc = cyc;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (tick[i] === 1'b1) begin
        tick_cnt[i]++;
        if (base_tick !== 1'b1) orphan++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] p);
    cfg_period = p;
    cfg_start  = 1'b1;
    step();
    cfg_start  = 1'b0;
  endtask

  task automatic wait_running(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      step();
      if (running === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic fire_irqs(input int n, output bit ok);
    irq_req += n;
    ok = 1'b0;
    for (int i = 0; i < 8 * n + 20 && !ok; i++) begin
      step();
      if (irq_served == irq_req) ok = 1'b1;
    end
    step();
    step();
  endtask

  task automatic set_channels(input int dv [N_CH], input logic [N_CH-1:0] en);
    for (int i = 0; i < N_CH; i++) ch_div[i*DIV_W +: DIV_W] = DIV_W'(dv[i]);
    ch_en = en;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step(); step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL reset_cfg_error: got %b want 0", cfg_error); end
    checks++; if (base_tick !== 1'b0) begin errors++; $display("FAIL reset_base_tick: got %b want 0", base_tick); end
    checks++; if (tick !== '0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
    checks++; if (tick_count !== 32'd0) begin errors++; $display("FAIL reset_tick_count: got %0d want 0", tick_count); end
    checks++; if (tmr_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b want 0", tmr_chipselect); end
    checks++; if (tmr_write_n !== 1'b1) begin errors++; $display("FAIL reset_write_n: got %b want 1", tmr_write_n); end
    checks++; if (tmr_address !== 3'd0 || tmr_writedata !== 16'd0) begin
      errors++; $display("FAIL reset_bus: got addr=%0d data=%04h want 0/0000", tmr_address, tmr_writedata);
    end
    reset_n = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_start();
    int          base;
    logic [2:0]  ea [4];
    logic        ew [4];
    logic [15:0] ed [4];
    logic [31:0] p;
    p = 32'd49999;
    ea = '{3'd2, 3'd3, 3'd1, 3'd0};
    ew = '{1'b1, 1'b1, 1'b1, 1'b0};
    ed = '{p[15:0], p[31:16], 16'h0007, 16'h0000};
    base = bus_log.size();
    pulse_start(p);
    checks++; if (!(tmr_chipselect === 1'b1 && tmr_write_n === 1'b0 && tmr_address === 3'd2)) begin
      errors++; $display("FAIL start_first_write: got cs=%b wn=%b addr=%0d want 1/0/2", tmr_chipselect, tmr_write_n, tmr_address);
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b want 1", busy); end
    step(); step(); step(); step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL start_running_early: got %b want 0 at +5", running); end
    step();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running_at_6: got %b want 1", running); end
    checks++; if (bus_log.size() - base != 4) begin
      errors++; $display("FAIL start_bus_count: got %0d want 4", bus_log.size() - base);
    end
    if (bus_log.size() - base >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (bus_log[base+i].addr !== ea[i] || bus_log[base+i].wr !== ew[i] || (ew[i] && bus_log[base+i].data !== ed[i])) begin
          errors++;
          $display("FAIL start_bus_%0d: got addr=%0d we=%b data=%04h want addr=%0d we=%b data=%04h",
                   i, bus_log[base+i].addr, bus_log[base+i].wr, bus_log[base+i].data, ea[i], ew[i], ed[i]);
        end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_busy_after: got %b want 0", busy); end
    $display("test_start done");
  endtask

  task automatic test_irq();
    int bt0, ack0;
    bit ok;
    bt0  = bt_cnt;
    ack0 = ack_cnt;
    fire_irqs(1, ok);
    exp_tc = exp_tc + 32'd1;
    checks++; if (!ok) begin errors++; $display("FAIL irq_served: got timeout want ack"); end
    checks++; if (bt_cnt - bt0 != 1) begin errors++; $display("FAIL irq_base_tick_cycles: got %0d want 1", bt_cnt - bt0); end
    checks++; if (bt_cyc - irq_rise_cyc != 1) begin errors++; $display("FAIL irq_latency: got %0d want 1", bt_cyc - irq_rise_cyc); end
    checks++; if (ack_cnt - ack0 != 1 || spur_ack != 0) begin
      errors++; $display("FAIL irq_ack_writes: got %0d spurious=%0d want 1/0", ack_cnt - ack0, spur_ack);
    end
    checks++; if (tick_count !== exp_tc) begin errors++; $display("FAIL irq_tick_count: got %0d want %0d", tick_count, exp_tc); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL irq_running: got %b want 1", running); end
    $display("test_irq done");
  endtask

  task automatic test_channels();
    int dv [N_CH];
    int t0 [N_CH];
    bit ok;
    dv = '{2, 0, 1, 3};
    set_channels(dv, 4'hF);
    pulse_start(32'd1000);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL restart_drop: got %b want 0", running); end
    wait_running(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL restart_running: got timeout want running"); end
    t0 = tick_cnt;
    fire_irqs(12, ok);
    exp_tc = exp_tc + 32'd12;
    checks++; if (!ok) begin errors++; $display("FAIL chan_irqs: got timeout want 12 acks"); end
    for (int i = 0; i < N_CH; i++) begin
      checks++;
      if (tick_cnt[i] - t0[i] != 12 / (dv[i] + 1)) begin
        errors++; $display("FAIL chan_%0d_ticks: got %0d want %0d", i, tick_cnt[i] - t0[i], 12 / (dv[i] + 1));
      end
    end
    checks++; if (tick_count !== exp_tc) begin errors++; $display("FAIL chan_tick_count: got %0d want %0d", tick_count, exp_tc); end
    checks++; if (orphan != 0) begin errors++; $display("FAIL chan_orphan_ticks: got %0d want 0", orphan); end
    $display("test_channels done");
  endtask

  task automatic test_random();
    int              dv [N_CH];
    int              t0 [N_CH];
    logic [N_CH-1:0] en;
    logic [31:0]     p;
    int              k, base, want;
    bit              ok;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N_CH; i++) begin
        dv[i] = int'($urandom_range(0, 5));
        en[i] = ($urandom_range(0, 3) != 0);
      end
      set_channels(dv, en);
      p = $urandom();
      if (p < 32'd2) p = 32'd2;
      base = bus_log.size();
      pulse_start(p);
      wait_running(20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_running: got timeout want running", r); end
      checks++;
      if (bus_log.size() - base < 2 || bus_log[base].data !== p[15:0] || bus_log[base+1].data !== p[31:16]) begin
        errors++; $display("FAIL rand%0d_period_words: want %04h/%04h", r, p[15:0], p[31:16]);
      end
      t0 = tick_cnt;
      k = int'($urandom_range(3, 20));
      fire_irqs(k, ok);
      exp_tc = exp_tc + 32'(k);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_irqs: got timeout want %0d acks", r, k); end
      for (int i = 0; i < N_CH; i++) begin
        want = en[i] ? k / (dv[i] + 1) : 0;
        checks++;
        if (tick_cnt[i] - t0[i] != want) begin
          errors++; $display("FAIL rand%0d_chan_%0d: got %0d want %0d (d=%0d en=%b k=%0d)", r, i, tick_cnt[i] - t0[i], want, dv[i], en[i], k);
        end
      end
      checks++; if (tick_count !== exp_tc) begin errors++; $display("FAIL rand%0d_tick_count: got %0d want %0d", r, tick_count, exp_tc); end
      $display("test_random round %0d: k=%0d period=%08h", r, k, p);
    end
  endtask

  task automatic test_stop_pend();
    int          base;
    bit          rose;
    logic [2:0]  ea [5];
    logic [15:0] ed [5];
    logic [31:0] p;
    p = 32'd5000;
    ea = '{3'd2, 3'd3, 3'd1, 3'd0, 3'd1};
    ed = '{p[15:0], p[31:16], 16'h0007, 16'h0000, 16'h0008};
    base = bus_log.size();
    pulse_start(p);
    step();
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    rose = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (running === 1'b1) rose = 1'b1;
    end
    checks++; if (rose) begin errors++; $display("FAIL stop_running: got 1 want 0 throughout"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_idle: got busy=%b want 0", busy); end
    checks++; if (run_bit !== 1'b0) begin errors++; $display("FAIL stop_timer: got run=%b want 0", run_bit); end
    checks++; if (bus_log.size() - base != 5) begin errors++; $display("FAIL stop_bus_count: got %0d want 5", bus_log.size() - base); end
    if (bus_log.size() - base >= 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (bus_log[base+i].addr !== ea[i] || bus_log[base+i].wr !== (i != 3) || (i != 3 && bus_log[base+i].data !== ed[i])) begin
          errors++;
          $display("FAIL stop_bus_%0d: got addr=%0d we=%b data=%04h want addr=%0d data=%04h",
                   i, bus_log[base+i].addr, bus_log[base+i].wr, bus_log[base+i].data, ea[i], ed[i]);
        end
      end
    end
    $display("test_stop_pend done");
  endtask

  task automatic test_cfg_error();
    int base;
    bit ok;
    base = bus_log.size();
    pulse_start(32'd1);
    checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", cfg_error); end
    for (int i = 0; i < 6; i++) step();
    checks++; if (bus_log.size() != base) begin errors++; $display("FAIL err_no_bus: got %0d xacts want 0", bus_log.size() - base); end
    checks++; if (busy !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL err_idle: got busy=%b running=%b want 0/0", busy, running); end
    pulse_start(32'd100);
    checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", cfg_error); end
    wait_running(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL err_restart_running: got timeout want running"); end
    checks++; if (bus_log.size() - base < 2 || bus_log[base].data !== 16'd100 || bus_log[base+1].data !== 16'd0) begin
      errors++; $display("FAIL err_period_words: want 0064/0000");
    end
    $display("test_cfg_error done");
  endtask

  task automatic test_check_fail_and_reset();
    int base;
    bit ok;
    stall = 1'b1;
    base = bus_log.size();
    pulse_start(32'd300);
    for (int i = 0; i < 6; i++) step();
    checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL chk_cfg_error: got %b want 1", cfg_error); end
    checks++; if (running !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL chk_idle: got running=%b busy=%b want 0/0", running, busy); end
    checks++; if (bus_log.size() - base != 4) begin errors++; $display("FAIL chk_bus_count: got %0d want 4", bus_log.size() - base); end
    stall = 1'b0;
    pulse_start(32'd400);
    wait_running(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL chk_recover: got timeout want running"); end
    irq_req++;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (base_tick === 1'b1) ok = 1'b1;
    end
    checks++; if (!ok || tick_count === 32'd0) begin errors++; $display("FAIL rst_precondition: got base_tick=%b count=%0d want in ACK", base_tick, tick_count); end
    reset_n = 1'b0;
    #1;
    checks++; if (base_tick !== 1'b0 || tick !== '0) begin errors++; $display("FAIL rst_ticks: got base=%b tick=%b want 0", base_tick, tick); end
    checks++; if (tmr_chipselect !== 1'b0 || tmr_write_n !== 1'b1) begin errors++; $display("FAIL rst_bus: got cs=%b wn=%b want 0/1", tmr_chipselect, tmr_write_n); end
    checks++; if (running !== 1'b0 || busy !== 1'b0 || cfg_error !== 1'b0) begin
      errors++; $display("FAIL rst_status: got run=%b busy=%b err=%b want 0", running, busy, cfg_error);
    end
    checks++; if (tick_count !== 32'd0) begin errors++; $display("FAIL rst_tick_count: got %0d want 0", tick_count); end
    step();
    $display("test_check_fail_and_reset done");
  endtask

  initial begin
    test_reset();
    test_start();
    test_irq();
    test_channels();
    test_random();
    test_stop_pend();
    test_cfg_error();
    test_check_fail_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
